// File: rtl/mem_march_bist_if.sv
// Single-port handshake memory bus: valid/ready request with write/read select,
// read data returned the cycle after a read handshake.
interface mem_march_bist_if #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned ADDR_WIDTH = 10
);
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0]      mem_wdata;
   logic                  mem_wr_rd;
   logic                  mem_valid;
   logic                  mem_ready;
   logic [WIDTH-1:0]      mem_rdata;

   modport master (
      output mem_addr,
      output mem_wdata,
      output mem_wr_rd,
      output mem_valid,
      input  mem_ready,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr,
      input  mem_wdata,
      input  mem_wr_rd,
      input  mem_valid,
      output mem_ready,
      output mem_rdata
   );
endinterface

// File: rtl/mem_march_bist.sv
// Three-pass march self-test master: write pattern, read/compare + write inverse,
// then read/compare inverse descending. Reports pass/fail and first-failure details.
module mem_march_bist #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned CNT_WIDTH  = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [WIDTH-1:0]      seed_i,
   mem_march_bist_if.master      mem,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  fail_o,
   output logic [CNT_WIDTH-1:0]  fail_cnt_o,
   output logic [ADDR_WIDTH-1:0] fail_addr_o,
   output logic [WIDTH-1:0]      fail_exp_o,
   output logic [WIDTH-1:0]      fail_got_o
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StW0    = 3'd1;
   localparam logic [2:0] StR0Rd  = 3'd2;
   localparam logic [2:0] StR0Cmp = 3'd3;
   localparam logic [2:0] StR0Wr  = 3'd4;
   localparam logic [2:0] StR1Rd  = 3'd5;
   localparam logic [2:0] StR1Cmp = 3'd6;
   localparam logic [2:0] StDone  = 3'd7;

   localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

   logic [2:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0]      seed_q, seed_d;
   logic                  fail_q, fail_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
   logic [WIDTH-1:0]      fexp_q, fexp_d;
   logic [WIDTH-1:0]      fgot_q, fgot_d;

   logic             hs;
   logic             cmp_state;
   logic             mismatch;
   logic [WIDTH-1:0] pat;
   logic [WIDTH-1:0] exp_data;

   // Size cast zero-extends or truncates the address to the data width.
   assign pat       = seed_q ^ WIDTH'(addr_q);
   assign cmp_state = (state_q == StR0Cmp) || (state_q == StR1Cmp);
   assign exp_data  = (state_q == StR0Cmp) ? pat : ~pat;
   assign mismatch  = cmp_state && (mem.mem_rdata != exp_data);
   assign hs        = mem.mem_valid && mem.mem_ready;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      seed_d  = seed_q;
      fail_d  = fail_q;
      cnt_d   = cnt_q;
      faddr_d = faddr_q;
      fexp_d  = fexp_q;
      fgot_d  = fgot_q;

      case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               state_d = StW0;
               addr_d  = '0;
               seed_d  = seed_i;
               fail_d  = 1'b0;
               cnt_d   = '0;
               faddr_d = '0;
               fexp_d  = '0;
               fgot_d  = '0;
            end
         end
         StW0: begin
            if (hs) begin
               if (addr_q == LastAddr) begin
                  state_d = StR0Rd;
                  addr_d  = '0;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         StR0Rd:  if (hs) state_d = StR0Cmp;
         StR0Cmp: state_d = StR0Wr;
         StR0Wr: begin
            // Terminal test precedes the step, so the counter never wraps.
            if (hs) begin
               if (addr_q == LastAddr) begin
                  state_d = StR1Rd;
               end else begin
                  addr_d  = addr_q + 1'b1;
                  state_d = StR0Rd;
               end
            end
         end
         StR1Rd:  if (hs) state_d = StR1Cmp;
         StR1Cmp: begin
            if (addr_q == '0) begin
               state_d = StDone;
            end else begin
               addr_d  = addr_q - 1'b1;
               state_d = StR1Rd;
            end
         end
         default: state_d = StIdle;
      endcase

      if (mismatch) begin
         fail_d = 1'b1;
         if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
         if (cnt_q == '0) begin
            faddr_d = addr_q;
            fexp_d  = exp_data;
            fgot_d  = mem.mem_rdata;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= StIdle;
         addr_q  <= '0;
         seed_q  <= '0;
         fail_q  <= 1'b0;
         cnt_q   <= '0;
         faddr_q <= '0;
         fexp_q  <= '0;
         fgot_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         seed_q  <= seed_d;
         fail_q  <= fail_d;
         cnt_q   <= cnt_d;
         faddr_q <= faddr_d;
         fexp_q  <= fexp_d;
         fgot_q  <= fgot_d;
      end
   end

   always_comb begin
      mem.mem_valid = (state_q == StW0) || (state_q == StR0Rd) ||
                      (state_q == StR0Wr) || (state_q == StR1Rd);
      mem.mem_wr_rd = (state_q == StW0) || (state_q == StR0Wr);
      mem.mem_addr  = addr_q;
      if (state_q == StW0) begin
         mem.mem_wdata = pat;
      end else if (state_q == StR0Wr) begin
         mem.mem_wdata = ~pat;
      end else begin
         mem.mem_wdata = '0;
      end
   end

   assign busy_o      = (state_q != StIdle) && (state_q != StDone);
   assign done_o      = (state_q == StDone);
   assign fail_o      = fail_q;
   assign fail_cnt_o  = cnt_q;
   assign fail_addr_o = faddr_q;
   assign fail_exp_o  = fexp_q;
   assign fail_got_o  = fgot_q;

endmodule

// File: tb/tb_mem_march_bist.sv
// Bench for mem_march_bist: behavioural handshake memory with backdoor faults,
// request-sequence scoreboard and per-scenario result checks.
module tb_mem_march_bist;
   localparam int unsigned WIDTH = 16;
   localparam int unsigned DEPTH = 1024;
   localparam int unsigned AW    = 10;
   localparam int unsigned CW    = 8;
   localparam int          LIMIT = 20000;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] seed;
   logic             busy, done, fail;
   logic [CW-1:0]    fail_cnt;
   logic [AW-1:0]    fail_addr;
   logic [WIDTH-1:0] fail_exp, fail_got;

   always #5 clk = ~clk;

   mem_march_bist_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus ();

   mem_march_bist #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
   ) dut (
      .clk_i(clk), .rst_i(rst_n), .start_i(start), .seed_i(seed), .mem(bus),
      .busy_o(busy), .done_o(done), .fail_o(fail), .fail_cnt_o(fail_cnt),
      .fail_addr_o(fail_addr), .fail_exp_o(fail_exp), .fail_got_o(fail_got)
   );

   typedef struct packed {
      logic             wr;
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] data;
   } req_t;

   req_t             exp_q[$];
   req_t             obs_q[$];
   logic [WIDTH-1:0] mem_arr [DEPTH];
   int               checks = 0;
   int               errors = 0;
   int               wr_hs = 0, rd_hs = 0, stalls = 0, hold_viol = 0;
   bit               rand_ready = 1'b0;
   int               bd_mode = 0;
   bit               bd_done = 1'b0;
   bit               hold_pend = 1'b0;
   logic [AW+WIDTH:0] hold_val;

   // Memory model: ready chosen for the cycle, then the handshake resolved before the edge.
   always @(negedge clk) begin
      req_t o;
      bus.mem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bd_mode == 0) bd_done = 1'b0;
      if (bd_mode != 0 && !bd_done && bus.mem_valid && !bus.mem_wr_rd) begin
         if (bd_mode == 1) mem_arr[16] = '0;
         else for (int i = 0; i < DEPTH; i++) mem_arr[i] = '0;
         bd_done = 1'b1;
      end
      if (hold_pend && (!bus.mem_valid ||
          {bus.mem_wr_rd, bus.mem_addr, bus.mem_wdata} !== hold_val)) hold_viol++;
      hold_pend = rst_n && bus.mem_valid && !bus.mem_ready;
      hold_val  = {bus.mem_wr_rd, bus.mem_addr, bus.mem_wdata};
      if (bus.mem_valid && !bus.mem_ready) stalls++;
      if (bus.mem_valid && bus.mem_ready) begin
         o.wr   = bus.mem_wr_rd;
         o.addr = bus.mem_addr;
         o.data = bus.mem_wr_rd ? bus.mem_wdata : '0;
         obs_q.push_back(o);
         if (bus.mem_wr_rd) begin
            mem_arr[bus.mem_addr] = bus.mem_wdata;
            wr_hs++;
         end else begin
            bus.mem_rdata = mem_arr[bus.mem_addr];
            rd_hs++;
         end
      end
   end

   task automatic push_expected(input logic [WIDTH-1:0] s);
      req_t e;
      for (int a = 0; a < DEPTH; a++) begin
         e.wr = 1'b1; e.addr = AW'(a); e.data = s ^ WIDTH'(a);
         exp_q.push_back(e);
      end
      for (int a = 0; a < DEPTH; a++) begin
         e.wr = 1'b0; e.addr = AW'(a); e.data = '0;
         exp_q.push_back(e);
         e.wr = 1'b1; e.data = ~(s ^ WIDTH'(a));
         exp_q.push_back(e);
      end
      for (int a = DEPTH - 1; a >= 0; a--) begin
         e.wr = 1'b0; e.addr = AW'(a); e.data = '0;
         exp_q.push_back(e);
      end
   endtask

   task automatic drain();
      req_t o, e;
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_extra got wr=%0d addr=%h data=%h required none",
                     o.wr, o.addr, o.data);
         end else begin
            e = exp_q.pop_front();
            if (o.wr !== e.wr || o.addr !== e.addr || (e.wr && o.data !== e.data)) begin
               errors++;
               $display("FAIL scoreboard_req got wr=%0d addr=%h data=%h required wr=%0d addr=%h data=%h",
                        o.wr, o.addr, o.data, e.wr, e.addr, e.data);
            end
         end
      end
   endtask

   // Starts a run; lat counts cycles from first valid to done (LIMIT+1 on timeout).
   task automatic do_run(input logic [WIDTH-1:0] s, input int bd, input int abort_rd,
                         input bit poke, output int lat, output logic [52:0] snap);
      int rd0;
      push_expected(s);
      bd_mode = bd;
      @(posedge clk); #1;
      start = 1'b1; seed = s;
      @(posedge clk); #1;
      start = 1'b0; seed = ~s;
      snap = {busy, done, fail, fail_cnt, fail_addr, fail_exp, fail_got};
      drain();
      lat = 0;
      rd0 = rd_hs;
      while (done !== 1'b1) begin
         if (abort_rd > 0 && (rd_hs - rd0) >= abort_rd) break;
         start = poke && (lat == 100);
         if (start) seed = 16'hFFFF;
         @(posedge clk); #1;
         lat++;
         drain();
         if (lat > LIMIT) break;
      end
      start = 1'b0;
      bd_mode = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; seed = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, fail, fail_cnt, fail_addr, fail_exp, fail_got, bus.mem_valid,
           bus.mem_wr_rd, bus.mem_addr, bus.mem_wdata} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got busy=%b done=%b fail=%b cnt=%h valid=%b addr=%h wdata=%h required all 0",
                  busy, done, fail, fail_cnt, bus.mem_valid, bus.mem_addr, bus.mem_wdata);
      end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset got busy=%b done=%b required 0 0", busy, done);
      end
   endtask

   task automatic check_clean(input string name, input int lat, input int req_lat);
      checks++;
      if (lat != req_lat) begin
         errors++;
         $display("FAIL %s_latency got %0d required %0d", name, lat, req_lat);
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || fail !== 1'b0 || fail_cnt !== '0) begin
         errors++;
         $display("FAIL %s_result got done=%b busy=%b fail=%b cnt=%0d required 1 0 0 0",
                  name, done, busy, fail, fail_cnt);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_missing_requests got %0d left required 0", name, exp_q.size());
      end
   endtask

   task automatic test_clean_pass();
      int lat; logic [52:0] snap;
      do_run(16'hA5A5, 0, 0, 1'b0, lat, snap);
      check_clean("clean", lat, 6 * DEPTH);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b1 || bus.mem_valid !== 1'b0) begin
         errors++;
         $display("FAIL done_hold got done=%b valid=%b required 1 0", done, bus.mem_valid);
      end
   endtask

   task automatic test_single_fault();
      int lat; logic [52:0] snap;
      do_run(16'hA5A5, 1, 0, 1'b0, lat, snap);
      checks++;
      if (lat != 6 * DEPTH) begin
         errors++;
         $display("FAIL fault_latency got %0d required %0d", lat, 6 * DEPTH);
      end
      checks++;
      if (fail !== 1'b1 || fail_cnt !== 8'd1 || fail_addr !== 10'h010 ||
          fail_exp !== 16'hA5B5 || fail_got !== 16'h0000) begin
         errors++;
         $display("FAIL fault_details got fail=%b cnt=%0d addr=%h exp=%h got=%h required 1 1 010 a5b5 0000",
                  fail, fail_cnt, fail_addr, fail_exp, fail_got);
      end
      checks++;
      if (mem_arr[16] !== 16'h5A4A) begin
         errors++;
         $display("FAIL fault_dump got %h required 5a4a", mem_arr[16]);
      end
   endtask

   task automatic test_restart_and_busy_start();
      int lat; logic [52:0] snap;
      do_run(16'h0F0F, 0, 0, 1'b1, lat, snap);
      checks++;
      if (snap !== {1'b1, 52'b0}) begin
         errors++;
         $display("FAIL restart_clear got %h required %h", snap, {1'b1, 52'b0});
      end
      check_clean("busy_start", lat, 6 * DEPTH);
   endtask

   task automatic test_saturate();
      int lat; logic [52:0] snap;
      do_run(16'h0000, 2, 0, 1'b0, lat, snap);
      checks++;
      if (fail !== 1'b1 || fail_cnt !== 8'hFF || fail_addr !== 10'h001 ||
          fail_exp !== 16'h0001 || fail_got !== 16'h0000) begin
         errors++;
         $display("FAIL saturate got fail=%b cnt=%0d addr=%h exp=%h got=%h required 1 255 001 0001 0000",
                  fail, fail_cnt, fail_addr, fail_exp, fail_got);
      end
      checks++;
      if (mem_arr[0] !== 16'hFFFF || mem_arr[DEPTH-1] !== 16'hFC00) begin
         errors++;
         $display("FAIL saturate_dump got %h %h required ffff fc00", mem_arr[0], mem_arr[DEPTH-1]);
      end
   endtask

   task automatic test_random_ready();
      int lat, st0, hv0; logic [52:0] snap;
      rand_ready = 1'b1;
      st0 = stalls; hv0 = hold_viol;
      do_run(16'hA5A5, 0, 0, 1'b0, lat, snap);
      rand_ready = 1'b0;
      check_clean("stall", lat, 6 * DEPTH + (stalls - st0));
      checks++;
      if (hold_viol != hv0 || stalls == st0) begin
         errors++;
         $display("FAIL stall_hold got violations=%0d stalls=%0d required 0 and >0",
                  hold_viol - hv0, stalls - st0);
      end
   endtask

   task automatic test_async_reset();
      int lat; logic [52:0] snap;
      do_run(16'h1234, 0, 5, 1'b0, lat, snap);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, fail, fail_cnt, fail_addr, fail_exp, fail_got, bus.mem_valid,
           bus.mem_wr_rd, bus.mem_addr, bus.mem_wdata} !== '0) begin
         errors++;
         $display("FAIL async_reset got busy=%b valid=%b wr=%b addr=%h wdata=%h required all 0",
                  busy, bus.mem_valid, bus.mem_wr_rd, bus.mem_addr, bus.mem_wdata);
      end
      repeat (3) @(posedge clk);
      #1;
      exp_q.delete();
      obs_q.delete();
      rst_n = 1'b1;
      do_run(16'h3C3C, 0, 0, 1'b0, lat, snap);
      check_clean("after_reset", lat, 6 * DEPTH);
   endtask

   initial begin
      test_reset();
      test_clean_pass();
      test_single_fault();
      test_restart_and_busy_start();
      test_saturate();
      test_random_ready();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
